// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the request-capture stage.
package irq_pkg;
    localparam int N       = 4;
    localparam int IW      = 2;
    localparam int TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;
endpackage

// File: rtl/rise_detect.sv
// Registers the request levels and flags 0->1 transitions.
module rise_detect #(
    parameter int N = irq_pkg::N
) (
    input  logic         clk,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] rise
);
    logic [N-1:0] req_q;

    // NOTE: req_q tracks req_in even during reset, so no reset branch is needed;
    // a level held through reset therefore never looks like an edge afterwards.
    always_ff @(posedge clk) begin
        req_q <= req_in;
    end

    assign rise = req_in & ~req_q;
endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture feeding an external priority encoder, plus a
// one-at-a-time irq/ack service handshake with timeout and retry.
module irq_pending_ctrl #(
    parameter int N       = irq_pkg::N,
    parameter int IW      = irq_pkg::IW,
    parameter int TIMEOUT = irq_pkg::TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_in,
    input  logic [N-1:0]  mask,
    input  logic          clr_ovf,
    input  logic [IW-1:0] idx,
    input  logic          ack,
    output logic [N-1:0]  pend,
    output logic          en_out,
    output logic          irq,
    output logic [IW-1:0] svc_idx,
    output logic [N-1:0]  ovf,
    output logic          to_flag
);
    import irq_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [N-1:0]  rise, clr_vec;
    logic          irq_q, irq_d;
    logic          to_flag_q, to_flag_d;
    logic [IW-1:0] svc_idx_q, svc_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit, ack_hit;

    rise_detect #(.N(N)) u_rise_detect (
        .clk    (clk),
        .req_in (req_in),
        .rise   (rise)
    );

    assign pend        = pending_q & ~mask;
    assign en_out      = |pend;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign ack_hit     = (state_q == ISSUE) && ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ovf_q     <= '0;
            irq_q     <= 1'b0;
            to_flag_q <= 1'b0;
            svc_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            to_flag_q <= to_flag_d;
            svc_idx_q <= svc_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_out) state_d = ISSUE;
            ISSUE:   if (ack || timeout_hit) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_d     = (state_d == ISSUE);
        svc_idx_d = (state_q == IDLE && en_out) ? idx : svc_idx_q;
        cnt_d     = (state_q == ISSUE && state_d == ISSUE) ? cnt_q + 1'b1 : '0;
        to_flag_d = (state_q == ISSUE) && !ack && timeout_hit;
        clr_vec   = '0;
        clr_vec[svc_idx_q] = ack_hit;
        // Set terms are OR-ed after the clear so a coinciding edge keeps the bit.
        pending_d = (pending_q & ~clr_vec) | rise;
        ovf_d     = (clr_ovf ? '0 : ovf_q) | (rise & pending_q);
    end

    assign irq     = irq_q;
    assign svc_idx = svc_idx_q;
    assign ovf     = ovf_q;
    assign to_flag = to_flag_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench: directed test-plan sequences then random traffic,
// every cycle compared against a behavioural model of the service rules.
module tb_irq_pending_ctrl;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in, mask;
    logic       clr_ovf, ack;
    logic [1:0] idx;
    logic [3:0] pend, ovf;
    logic       en_out, irq, to_flag;
    logic [1:0] svc_idx;

    int n_tests = 0;
    int n_fail  = 0;

    irq_pending_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .mask    (mask),
        .clr_ovf (clr_ovf),
        .idx     (idx),
        .ack     (ack),
        .pend    (pend),
        .en_out  (en_out),
        .irq     (irq),
        .svc_idx (svc_idx),
        .ovf     (ovf),
        .to_flag (to_flag)
    );

    always #5 clk = ~clk;

    // Encoder beside the block: highest set bit of pend.
    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (pend[i]) idx = 2'(i);
    end

    // Behavioural model state.
    bit [3:0] m_prev, m_pending, m_ovf;
    bit       m_busy, m_gap, m_to;
    int       m_svc, m_age;

    function automatic int top_bit(bit [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit [3:0] rise, old, clr, vis;
        if (rst) begin
            m_pending = '0; m_ovf = '0; m_busy = 0; m_gap = 0; m_to = 0;
            m_svc = 0; m_age = 0; m_prev = req_in;
            return;
        end
        rise   = req_in & ~m_prev;
        m_prev = req_in;
        old    = m_pending;
        vis    = old & ~mask;
        clr    = '0;
        m_to   = 0;
        if (m_busy) begin
            if (ack) begin
                clr[m_svc] = 1'b1;
                m_busy = 0; m_gap = 1;
            end else if (m_age == TO - 1) begin
                m_busy = 0; m_gap = 1; m_to = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (vis != 0) begin
            m_svc = top_bit(vis); m_busy = 1; m_age = 0;
        end
        m_ovf     = (clr_ovf ? 4'b0 : m_ovf) | (rise & old);
        m_pending = (old & ~clr) | rise;
    endtask

    task automatic cycle();
        bit [3:0] exp_pend;
        @(posedge clk);
        model_edge();
        #1;
        exp_pend = m_pending & ~mask;
        check("pend",    32'(pend),    32'(exp_pend));
        check("en_out",  32'(en_out),  32'(exp_pend != 0));
        check("irq",     32'(irq),     32'(m_busy));
        check("svc_idx", 32'(svc_idx), 32'(m_svc));
        check("ovf",     32'(ovf),     32'(m_ovf));
        check("to_flag", 32'(to_flag), 32'(m_to));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_irq(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (irq === 1'b1) return;
            cycle();
        end
        check("irq_wait_timeout", 32'(irq), 32'd1);
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req_in = v; cycle(); req_in = 4'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1; cycle(); ack = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_in = '0; mask = '0; clr_ovf = 0; ack = 0;
        m_prev = '0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Single request, service, ack.
        pulse_req(4'b0001);
        wait_irq(5);
        do_ack();
        cycles(3);

        // Three simultaneous requests served 2,1,0.
        req_in = 4'b0111; cycle();
        for (int k = 0; k < 3; k++) begin
            wait_irq(6);
            do_ack();
        end
        req_in = 4'b0; cycles(3);

        // Masked highest channel, then unmasked.
        mask = 4'b1000;
        pulse_req(4'b1010);
        wait_irq(5);
        do_ack();
        mask = 4'b0000;
        wait_irq(5);
        do_ack();
        cycles(3);

        // Timeout with no ack, irq width, then retry acked.
        pulse_req(4'b0100);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (irq) n++;
            if (to_flag) break;
        end
        check("timeout_irq_len", 32'(n), 32'(TO));
        wait_irq(5);
        check("retry_svc", 32'(svc_idx), 32'd2);
        do_ack();
        cycles(3);

        // Overrun, clear, and rise coinciding with ack.
        pulse_req(4'b0100);
        cycle();
        pulse_req(4'b0100);
        cycle();
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        wait_irq(20);
        ack = 1'b1; req_in = 4'b0100; cycle();
        ack = 1'b0; req_in = 4'b0000;
        cycles(3);
        wait_irq(5);
        do_ack();
        cycles(3);

        // Levels held through reset, then reset during ISSUE.
        rst = 1'b1; req_in = 4'b1111; cycles(3);
        rst = 1'b0; cycles(4);
        req_in = 4'b0; cycles(2);
        pulse_req(4'b0001);
        wait_irq(5);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("irq_after_rst", 32'(irq), 32'd0);
        cycles(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req_in[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) mask = 4'($urandom_range(0, 15));
            ack     = ($urandom_range(0, 3) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0; ack = 0; clr_ovf = 0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
